bcd_serial_adder: RTL
=====================

// Module: bcd_serial_adder
// PURPOSE
//  Multi-digit packed-BCD adder that processes one decimal digit per clock, LSD first.
//  Sits directly upstream of the result consumer and drives the combinational
//  bcd_digit_add stage, a 4-bit ripple of fulladd cells plus +6 correction.
//  Operands and the result cross the block boundary on valid/ready handshakes.
//  Invalid BCD input digits are flagged.
// PARAMETERS
//  NDIGITS  4  number of BCD digits per operand (>=1); operand width = 4*NDIGITS
// PORTS
//  clk        in   1          rising-edge clock, single domain
//  reset      in   1          synchronous, active-high reset
//  in_valid   in   1          operand set a/b/cin present
//  in_ready   out  1          block can accept operands (IDLE only)
//  a          in   4*NDIGITS  packed BCD operand A, digit0 = a[3:0]
//  b          in   4*NDIGITS  packed BCD operand B
//  cin        in   1          decimal carry-in
//  out_valid  out  1          sum/cout/err valid
//  out_ready  in   1          consumer accepts result
//  sum        out  4*NDIGITS  packed BCD sum
//  cout       out  1          decimal carry-out of the MSD
//  err        out  1          some input digit of a or b was >9
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; err=0; idx=0.
//  - FSM states IDLE, RUN, DONE.
//  - IDLE: in_ready=1. On in_valid&in_ready: latch a, b; carry<=cin; idx<=0; err<=0; sum<=0; go to RUN.
//  - RUN: in_ready=0.
//    - Each cycle feed digit idx of a, b and carry to bcd_digit_add.
//    - bin = a_d + b_d + carry (5 bits, 0..19 for valid input, up to 31 otherwise).
//    - If bin>9: digit = (bin+6)[3:0], carry_next = 1. Else: digit = bin[3:0], carry_next = 0.
//    - Write the digit into sum[4*idx +: 4]; carry<=carry_next; err<=err | (a_d>9) | (b_d>9).
//    - If idx==NDIGITS-1: cout<=carry_next, go to DONE. Else idx<=idx+1.
//  - DONE: out_valid=1. sum, cout and err are held stable while out_valid=1 and out_ready=0.
//    On out_ready: go to IDLE, out_valid<=0 on the next edge.
//  - Latency: out_valid rises exactly NDIGITS cycles after the accepting edge.
//    Minimum issue interval is NDIGITS+2 cycles (no overlap of operations).
//  - out_ready asserted before out_valid has no effect. in_valid is ignored outside IDLE.
//  - Invalid digit (>9): the correction rule still applies, the result is undefined-but-deterministic,
//    and err=1 for that result.
//  - Reset mid-RUN or mid-DONE: abort immediately, return to the reset values, and drop the pending result.
//  - All registered outputs are glitch-free; in_ready and out_valid decode directly from the state.
//  - idx width = $clog2(NDIGITS), minimum 1 bit.
// STRUCTURE
//  - bcd_pkg holds:
//    - state typedef {IDLE, RUN, DONE}
//    - DIGIT_W=4
//    - BCD_MAX=9
//    - BCD_CORR=6
//  - Sub-module bcd_digit_add (combinational): a_d, b_d, ci -> bin, digit, co.
//    Built as four fulladd instances plus the >9 detect and +6 correct.
//  - Top level contains the FSM, operand registers, idx counter, carry register and sum register.
// TESTING
//  1. NDIGITS=4, a=0x1234, b=0x4321, cin=0 -> after 4 cycles: sum=0x5555, cout=0, err=0.
//  2. a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1. Carry ripples through every digit.
//  3. a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1. Max digit sum 19 each step.
//  4. a=0x00A0, b=0x0000 -> err=1. Next op a=0x0001, b=0x0002 -> sum=0x0003, err=0.
//  5. Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored.
//     Then out_ready=1 -> IDLE with in_ready=1.
//  6. reset at RUN idx=2 -> next cycle: in_ready=1, out_valid=0, sum=0.
//     A fresh op (0x0005+0x0005) -> sum=0x0010.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the serial BCD adder
// Purpose: FSM state encoding and decimal-digit constants used by the
//          adder top level and its digit stage.
// Ports:   none (package)
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W  = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_CORR = 6;

endpackage

// File: rtl/bcd_serial_adder_if.sv
// rtl/bcd_serial_adder_if.sv - operand/result handshake bundle for the serial BCD adder
// Purpose: groups the operand-side and result-side valid/ready handshakes.
// Signals: in_valid/in_ready/a/b/cin  operand transfer (master -> slave)
//          out_valid/out_ready/sum/cout/err  result transfer (slave -> master)
// Modports: master = operand source and result consumer, slave = the adder.
interface bcd_serial_adder_if #(
  parameter int NDIGITS = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NDIGITS-1:0]   a;
  logic [4*NDIGITS-1:0]   b;
  logic                   cin;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NDIGITS-1:0]   sum;
  logic                   cout;
  logic                   err;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, err
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, err
  );
endinterface

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single-digit BCD add with +6 correction
// Purpose: adds two BCD digits and a decimal carry, then corrects to BCD.
// Ports:   a_d, b_d [3:0], ci (in)
//          bin [4:0]   raw binary sum a_d + b_d + ci
//          digit [3:0] corrected decimal digit
//          co          decimal carry out (bin > 9)
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_d,
  input  logic [DIGIT_W-1:0] b_d,
  input  logic               ci,
  output logic [DIGIT_W:0]   bin,
  output logic [DIGIT_W-1:0] digit,
  output logic               co
);
  logic [DIGIT_W:0]   c;
  logic [DIGIT_W-1:0] s;
  logic [DIGIT_W:0]   corr;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_ripple
    fulladd u_fa (
      .x  (a_d[i]),
      .y  (b_d[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign bin  = {c[DIGIT_W], s};
  assign co   = (bin > (DIGIT_W+1)'(BCD_MAX));
  // Wrapping the +6 into 4 bits drops the decade that co already carries out.
  assign corr = bin + (DIGIT_W+1)'(BCD_CORR);
  assign digit = co ? corr[DIGIT_W-1:0] : bin[DIGIT_W-1:0];
endmodule

// File: rtl/fulladd.sv
// rtl/fulladd.sv - one-bit full adder cell
// Purpose: ripple element of the binary digit sum.
// Ports:   x, y, ci (in) -> s (sum bit), co (carry out)
module fulladd (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - multi-digit packed BCD adder, one digit per clock, LSD first
// Purpose: accepts an operand pair, adds one decimal digit per cycle and
//          presents the packed BCD sum, carry-out and invalid-digit flag.
// Ports:   clk    rising-edge clock
//          reset  synchronous active-high reset
//          io     handshake bundle (slave): in_valid/in_ready/a/b/cin,
//                 out_valid/out_ready/sum/cout/err
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  bcd_serial_adder_if.slave   io
);
  localparam int W     = DIGIT_W * NDIGITS;
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  state_t             state, state_next;
  logic [W-1:0]       a_q, b_q, sum_q;
  logic               carry, cout_q, err_q;
  logic [IDX_W-1:0]   idx;
  logic               last_digit;

  logic [DIGIT_W-1:0] a_d, b_d, dig;
  logic [DIGIT_W:0]   unused_bin;
  logic               dig_co;

  assign a_d        = a_q[DIGIT_W*idx +: DIGIT_W];
  assign b_d        = b_q[DIGIT_W*idx +: DIGIT_W];
  assign last_digit = (idx == IDX_W'(NDIGITS-1));

  bcd_digit_add u_digit (
    .a_d   (a_d),
    .b_d   (b_d),
    .ci    (carry),
    .bin   (unused_bin),
    .digit (dig),
    .co    (dig_co)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (io.in_valid) state_next = RUN;
      RUN:     if (last_digit)  state_next = DONE;
      DONE:    if (io.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            a_q   <= io.a;
            b_q   <= io.b;
            carry <= io.cin;
            idx   <= '0;
            err_q <= 1'b0;
            sum_q <= '0;
          end
        end
        RUN: begin
          sum_q[DIGIT_W*idx +: DIGIT_W] <= dig;
          carry <= dig_co;
          err_q <= err_q | (a_d > DIGIT_W'(BCD_MAX)) | (b_d > DIGIT_W'(BCD_MAX));
          if (last_digit) cout_q <= dig_co;
          else            idx    <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;
  assign io.err       = err_q;
endmodule
